// File: rtl/riptide_pkg.sv
// Shared definitions for the riptide fabric blocks.
//   ARB_NREQ : number of requesters on a round-robin arbiter
//   arb_sel_t: requester index / mux select type
//   rr_pick  : round-robin winner search starting after the last grant
package riptide_pkg;

    localparam int ARB_NREQ = 4;

    typedef logic [1:0] arb_sel_t;

    // First set valid bit scanning last+1, last+2, last+3, last (mod 4).
    // Returns last when nothing is valid; callers qualify with |valid.
    function automatic arb_sel_t rr_pick(input arb_sel_t last,
                                         input logic [ARB_NREQ-1:0] valid);
        arb_sel_t idx;
        arb_sel_t pick;
        logic     found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= ARB_NREQ; k++) begin
            idx = last + arb_sel_t'(k);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4to1.sv
// One-bit 4:1 multiplexer.
//   d0..d3 : data inputs
//   s0, s1 : select bits, {s1, s0} picks d0..d3
//   y      : selected output
module mux4to1 (
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic s0,
    input  logic s1,
    output logic y
);

    always_comb begin
        case ({s1, s0})
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/arb4to1_rr.sv
// Four-input round-robin arbiter with a one-entry registered output stage.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : per-requester request valid
//   in_data    : per-requester data word
//   in_ready   : one-hot (or zero) accept strobe to the winning requester
//   out_valid  : output register holds a word
//   out_data   : registered winner data
//   out_ready  : downstream accepts the word
//   out_src    : requester index of the word in the output register
//   sel        : combinational mux select, {s1, s0}
module arb4to1_rr
    import riptide_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ARB_NREQ-1:0]               in_valid,
    input  logic [ARB_NREQ-1:0][WIDTH-1:0]    in_data,
    output logic [ARB_NREQ-1:0]               in_ready,
    output logic                              out_valid,
    output logic [WIDTH-1:0]                  out_data,
    input  logic                              out_ready,
    output logic [1:0]                        out_src,
    output logic [1:0]                        sel
);

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_data;
    arb_sel_t             r_out_src;
    arb_sel_t             r_last;

    logic                 w_load;
    logic                 w_grant;
    arb_sel_t             w_winner;
    logic [WIDTH-1:0]     w_mux;

    // Register can take a new word when empty or when draining this cycle.
    assign w_load   = !r_out_valid || out_ready;
    assign w_winner = rr_pick(r_last, in_valid);
    // Reset blocks grants so no requester sees an accept that gets discarded.
    assign w_grant  = w_load && (|in_valid) && !reset;

    always_comb begin
        in_ready = '0;
        sel      = r_last;
        if (w_grant) begin
            in_ready[w_winner] = 1'b1;
            sel                = w_winner;
        end
    end

    // Per-bit mux bank steering the winner's data into the output register.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_mux
        mux4to1 u_mux (
            .d0 (in_data[0][i]),
            .d1 (in_data[1][i]),
            .d2 (in_data[2][i]),
            .d3 (in_data[3][i]),
            .s0 (sel[0]),
            .s1 (sel[1]),
            .y  (w_mux[i])
        );
    end

    // Output register and round-robin pointer; last moves only on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_last      <= arb_sel_t'(3);
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_out_src   <= w_winner;
            r_last      <= w_winner;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_arb4to1_rr.sv
// Self-checking bench for arb4to1_rr: directed scenarios plus a random
// phase, all compared every cycle against a behavioural reference model.
module tb_arb4to1_rr;

    logic             clk;
    logic             reset;
    logic [3:0]       in_valid;
    logic [3:0][31:0] in_data;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;
    logic [1:0]       out_src;
    logic [1:0]       sel;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_full;
    logic [31:0] m_data;
    int          m_src;
    int          m_last;
    int          last_grant;

    arb4to1_rr #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_src   (out_src),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_data = 32'h0;
        m_src  = 0;
        m_last = 3;
    endtask

    // One clock: check all outputs against the model, then advance model.
    task automatic step();
        int          w;
        bit          grant;
        logic [3:0]  exp_rdy;
        int          exp_sel;
        #1;
        w = -1;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (w < 0 && in_valid[idx]) w = idx;
        end
        grant   = (!m_full || out_ready) && (w >= 0) && !reset;
        exp_rdy = grant ? 4'(1 << w) : 4'b0000;
        exp_sel = grant ? w : m_last;
        chk("in_ready",  32'(in_ready),  32'(exp_rdy));
        chk("sel",       32'(sel),       32'(exp_sel));
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("out_data",  out_data,       m_data);
        chk("out_src",   32'(out_src),   32'(m_src));
        @(posedge clk);
        last_grant = -1;
        if (reset) begin
            model_reset();
        end else if (grant) begin
            m_full     = 1'b1;
            m_data     = in_data[w];
            m_src      = w;
            m_last     = w;
            last_grant = w;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    initial begin : stim
        int          seq [6];
        logic [31:0] held_data;
        logic [1:0]  held_src;
        bit          pend [4];

        seq = '{0, 1, 2, 3, 0, 1};
        reset     = 1'b1;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i] = 32'h0;
        model_reset();
        last_grant = -1;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset values, with requests asserted during reset
        in_valid = 4'b1111;
        step();
        chk("reset_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;
        in_valid = 4'b0000;

        // Single requester
        in_valid   = 4'b0100;
        in_data[2] = 32'hA5A5_0002;
        out_ready  = 1'b1;
        #1;
        chk("single_ready", 32'(in_ready), 32'h4);
        chk("single_sel",   32'(sel),      32'h2);
        step();
        in_valid = 4'b0000;
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data",  out_data,       32'hA5A5_0002);
        chk("single_src",   32'(out_src),   32'h2);
        step();

        // All four continuously valid: strict rotation from requester 0
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i] = 32'hC0DE_0000 + 32'(i);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_seq",   32'(out_src),   32'(seq[k]));
            chk("rr_valid", 32'(out_valid), 32'h1);
            chk("rr_data",  out_data,       32'hC0DE_0000 + 32'(seq[k]));
        end

        // Backpressure: full with out_ready low for 5 cycles
        out_ready = 1'b0;
        held_data = out_data;
        held_src  = out_src;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_ready", 32'(in_ready), 32'h0);
            chk("bp_data",  out_data,      held_data);
            chk("bp_src",   32'(out_src),  32'(held_src));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_next", 32'(in_ready), 32'(4'(1 << ((int'(held_src) + 1) % 4))));
        step();

        // Drain and accept together: last = 1, requesters 1 and 3 valid
        do_reset();
        in_valid  = 4'b0010;
        out_ready = 1'b1;
        step();
        in_valid = 4'b1010;
        step();
        chk("da_src3",   32'(out_src),   32'h3);
        chk("da_valid3", 32'(out_valid), 32'h1);
        in_valid = 4'b0010;
        step();
        chk("da_src1",   32'(out_src),   32'h1);
        chk("da_valid1", 32'(out_valid), 32'h1);
        in_valid = 4'b0000;
        step();

        // Idle skip: only requester 0, granted back-to-back
        do_reset();
        in_valid = 4'b0001;
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("idle_ready", 32'(in_ready), 32'h1);
            step();
            chk("idle_valid", 32'(out_valid), 32'h1);
            chk("idle_src",   32'(out_src),   32'h0);
        end

        // Reset mid-operation while full and all requesting
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(in_ready), 32'h0);
        step();
        chk("rst_valid", 32'(out_valid), 32'h0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_first", 32'(in_ready), 32'h1);
        step();

        // Random phase honouring the hold-until-granted protocol
        do_reset();
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                    pend[i]    = 1'b1;
                    in_data[i] = $urandom;
                end
                in_valid[i] = pend[i];
            end
            out_ready = ($urandom_range(3, 0) != 0);
            step();
            if (last_grant >= 0) pend[last_grant] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
